// File: rtl/alu_seq_mul.sv
// Execute-stage ALU: and/or/add/sub resolve combinationally in the same cycle.
// MUL runs as an iterative shift-add over WIDTH/STEP cycles, and stall_o holds
// the front of the pipeline until the product is presented in the DONE cycle.
module alu_seq_mul #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             stall_o
);

    localparam int N     = WIDTH / STEP;
    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] mcand_reg, mcand_next;
    logic [WIDTH-1:0] mplier_reg, mplier_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic [WIDTH-1:0] pp [STEP];
    logic [WIDTH-1:0] step_sum;
    logic [WIDTH-1:0] alu_res;
    logic             start;

    // One partial product per retired multiplier bit: the multiplicand shifted
    // into place when that bit is set, zero otherwise.
    genvar gi;
    generate
        for (gi = 0; gi < STEP; gi++) begin : g_pp
            assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
        end
    endgenerate

    // Sum of this cycle's partial products, i.e. mcand * mplier[STEP-1:0].
    always_comb begin
        step_sum = '0;
        for (int i = 0; i < STEP; i++) begin
            step_sum = step_sum + pp[i];
        end
    end

    // Single-cycle result; undefined codes (and MUL itself) produce zero.
    always_comb begin
        alu_res = '0;
        case (ALUCtrl_i)
            OP_AND:  alu_res = data1_i & data2_i;
            OP_OR:   alu_res = data1_i | data2_i;
            OP_ADD:  alu_res = data1_i + data2_i;
            OP_SUB:  alu_res = data1_i - data2_i;
            default: alu_res = '0;
        endcase
    end

    // A squashed instruction must never launch a multiply.
    assign start = (state_reg == IDLE) && valid_i && (ALUCtrl_i == OP_MUL) && !flush_i;

    // Next-state, datapath updates and outputs for the multiply sequencer.
    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        cnt_next    = cnt_reg;
        data_o      = '0;
        stall_o     = 1'b0;
        case (state_reg)
            IDLE: begin
                data_o = alu_res;
                if (start) begin
                    stall_o     = 1'b1;
                    acc_next    = '0;
                    mcand_next  = data1_i;
                    mplier_next = data2_i;
                    cnt_next    = '0;
                    state_next  = BUSY;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    acc_next   = '0;
                    state_next = IDLE;
                end else begin
                    acc_next    = acc_reg + step_sum;
                    mcand_next  = mcand_reg << STEP;
                    mplier_next = mplier_reg >> STEP;
                    cnt_next    = cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_STEP) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                // The pipeline advances this cycle, so always fall back to IDLE.
                data_o     = acc_reg;
                state_next = IDLE;
                if (flush_i) begin
                    acc_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign zero_o = (data_o == '0);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_next;
        end
    end

endmodule

// File: tb/tb_alu_seq_mul.sv
// Directed bench for alu_seq_mul: one STEP=1 instance (a) and one STEP=4
// instance (b). Expected results are queued when stimulus is driven and popped
// when the DUT presents its output.
module tb_alu_seq_mul;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         va, fa, vb, fb;
    logic [2:0]   opa, opb;
    logic [W-1:0] a1, a2, b1, b2;
    logic [W-1:0] ya, yb;
    logic         za, zb, sa, sb;

    alu_seq_mul #(.WIDTH(W), .STEP(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .valid_i(va), .flush_i(fa), .ALUCtrl_i(opa),
        .data1_i(a1), .data2_i(a2), .data_o(ya), .zero_o(za), .stall_o(sa)
    );

    alu_seq_mul #(.WIDTH(W), .STEP(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .valid_i(vb), .flush_i(fb), .ALUCtrl_i(opb),
        .data1_i(b1), .data2_i(b2), .data_o(yb), .zero_o(zb), .stall_o(sb)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
            $display("[%0t] %s observed=0x%h expected=0x%h ok", $time, tag, obs, exp);
        end else begin
            n_fail++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic f, input logic [2:0] op,
                         input logic [W-1:0] x, input logic [W-1:0] y);
        if (sel) begin
            vb = v; fb = f; opb = op; b1 = x; b2 = y;
        end else begin
            va = v; fa = f; opa = op; a1 = x; a2 = y;
        end
    endtask

    function automatic logic [W-1:0] dout(input bit sel);
        return sel ? yb : ya;
    endfunction

    function automatic logic zout(input bit sel);
        return sel ? zb : za;
    endfunction

    function automatic logic sout(input bit sel);
        return sel ? sb : sa;
    endfunction

    // Single-cycle op on instance a, checked in the same cycle.
    task automatic alu_op(input string tag, input logic [2:0] op,
                          input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] e);
        logic [W-1:0] ex;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, op, x, y);
        exp_q.push_back(e);
        @(negedge clk);
        ex = exp_q.pop_front();
        check({tag, ".data"}, ya, ex);
        check({tag, ".zero"}, W'(za), W'(ex == '0));
        check({tag, ".stall"}, W'(sa), '0);
    endtask

    // Launch a mul, count stall cycles (bounded), then check the DONE cycle.
    task automatic mul(input bit sel, input string tag, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int nstall);
        logic [W-1:0] p;
        logic [W-1:0] ex;
        int cyc;
        p = x * y;
        @(posedge clk); #1;
        drive(sel, 1'b1, 1'b0, 3'b101, x, y);
        exp_q.push_back(p);
        cyc = 0;
        @(negedge clk);
        while (sout(sel) && cyc < 200) begin
            cyc++;
            if (cyc == 5) check({tag, ".busy_data"}, dout(sel), '0);
            @(negedge clk);
        end
        ex = exp_q.pop_front();
        check({tag, ".stall_cycles"}, W'(cyc), W'(nstall));
        check({tag, ".data"}, dout(sel), ex);
        check({tag, ".zero"}, W'(zout(sel)), W'(ex == '0));
    endtask

    // Drop the instruction and confirm the block sits idle.
    task automatic idle_chk(input bit sel, input string tag);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 3'b000, '0, '0);
        @(negedge clk);
        check({tag, ".stall"}, W'(sout(sel)), '0);
        check({tag, ".data"}, dout(sel), '0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, '0, '0);
        drive(1'b1, 1'b0, 1'b0, 3'b000, '0, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset.a.data", ya, '0);
        check("reset.a.zero", W'(za), W'(1));
        check("reset.a.stall", W'(sa), '0);
        check("reset.b.stall", W'(sb), '0);

        alu_op("add", 3'b011, 32'd7, 32'd5, 32'd12);
        alu_op("sub", 3'b100, 32'd5, 32'd5, 32'd0);
        alu_op("and", 3'b001, 32'hF0F0, 32'hFF00, 32'hF000);
        alu_op("or", 3'b010, 32'h0F, 32'hF0, 32'hFF);
        alu_op("sub_wrap", 3'b100, 32'd0, 32'd1, 32'hFFFF_FFFF);
        alu_op("undef", 3'b111, 32'd3, 32'd4, 32'd0);

        // mul code without valid_i must not start
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 3'b101, 32'd3, 32'd4);
        @(negedge clk);
        check("novalid.stall0", W'(sa), '0);
        @(negedge clk);
        check("novalid.stall1", W'(sa), '0);

        // flush outranks start
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 3'b101, 32'd3, 32'd4);
        @(negedge clk);
        check("flushstart.stall0", W'(sa), '0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, '0, '0);
        @(negedge clk);
        check("flushstart.stall1", W'(sa), '0);

        mul(1'b0, "mul3x4", 32'd3, 32'd4, 33);
        idle_chk(1'b0, "after3x4");
        mul(1'b0, "mulffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        idle_chk(1'b0, "afterff");
        mul(1'b0, "mul8x2", 32'h8000_0000, 32'd2, 33);
        idle_chk(1'b0, "after8x2");
        mul(1'b0, "mul6x7", 32'd6, 32'd7, 33);
        mul(1'b0, "mul9x9", 32'd9, 32'd9, 33);
        idle_chk(1'b0, "after9x9");

        // reset in BUSY iteration 10
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 3'b101, 32'd5, 32'd7);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst.busy_stall", W'(sa), W'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, '0, '0);
        @(negedge clk);
        check("rst.after_stall", W'(sa), '0);
        check("rst.after_data", ya, '0);
        @(negedge clk);
        check("rst.after_stall2", W'(sa), '0);
        mul(1'b0, "mul2x3", 32'd2, 32'd3, 33);
        idle_chk(1'b0, "after2x3");

        // STEP=4 instance
        mul(1'b1, "b.mul1234x10", 32'h1234, 32'h10, 9);
        idle_chk(1'b1, "b.after1234");

        // flush in BUSY: back to IDLE with no result cycle
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 3'b101, 32'h1234, 32'h10);
        repeat (3) @(posedge clk);
        #1 fb = 1'b1;
        @(negedge clk);
        check("b.flush.busy_stall", W'(sb), W'(1));
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 3'b101, '0, '0);
        @(negedge clk);
        check("b.flush.next_stall", W'(sb), '0);
        check("b.flush.next_data", yb, '0);
        @(negedge clk);
        check("b.flush.later_stall", W'(sb), '0);
        check("b.flush.later_data", yb, '0);
        mul(1'b1, "b.mul5x6", 32'd5, 32'd6, 9);
        idle_chk(1'b1, "b.after5x6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
